srl_fifo_read_ctrl: RTL and testbench

SRL_FIFO_READ_CTRL -- requirements
Module: srl_fifo_read_ctrl

---
 rtl/srl_fifo_read_ctrl.sv | 116 +++++++++++
 tb/tb_srl_fifo_read_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srl_fifo_read_ctrl.sv
// Shift-register FIFO with occupancy counter and registered flags.
// Define SRL_FIFO_OUT_REG_EN to add an output register stage (capacity DEPTH+1).
module srl_fifo_read_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
);

  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  full_n_q, full_n_d;
  logic                  wr_acc;
  logic                  pop;
  logic [DATA_WIDTH-1:0] srl_head;

  assign wr_acc   = if_write & full_n_q;
  assign srl_head = srl_q[addr_q];
  assign if_full_n = full_n_q;

  // Storage is deliberately left unreset; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      srl_q[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!wr_acc && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    addr_d   = (cnt_d == '0) ? '0 : ADDR_WIDTH'(cnt_d - 1'b1);
    full_n_d = (cnt_d != CNT_MAX);
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      full_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      full_n_q <= full_n_d;
    end
  end

`ifdef SRL_FIFO_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  rd_acc;

  assign rd_acc = if_read & out_valid_q;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign pop    = (cnt_q != '0) & (~out_valid_q | rd_acc);

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (pop) begin
      out_data_d  = srl_head;
      out_valid_d = 1'b1;
    end else if (rd_acc) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign if_dout    = out_data_q;
  assign if_empty_n = out_valid_q;
`else
  logic empty_n_q, empty_n_d;

  assign pop       = if_read & empty_n_q;
  assign empty_n_d = (cnt_d != '0);

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      empty_n_q <= 1'b0;
    end else begin
      empty_n_q <= empty_n_d;
    end
  end

  assign if_dout    = srl_head;
  assign if_empty_n = empty_n_q;
`endif

endmodule

// File: tb/tb_srl_fifo_read_ctrl.sv
// Self-checking bench for srl_fifo_read_ctrl: four depths checked against a queue model.
module tb_srl_fifo_read_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef SRL_FIFO_OUT_REG_EN
  localparam bit OREG = 1'b1;
`else
  localparam bit OREG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr      [N];
  logic          rd      [N];
  logic [DW-1:0] din     [N];
  logic          full_n  [N];
  logic          empty_n [N];
  logic [DW-1:0] dout    [N];

  int checks   = 0;
  int failures = 0;
  int dep [N] = '{1, 2, 4, 5};

  // Model: ring buffer of words held in the shift array, plus an optional head stage.
  logic [DW-1:0] mbuf [N][8];
  int            mcnt [N];
  int            mrd  [N];
  bit            hv   [N];
  logic [DW-1:0] head [N];

  always #5 clk = ~clk;

  srl_fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .DEPTH(1)) u_d1 (
    .clk(clk), .ap_rst_n(rst_n), .if_write(wr[0]), .if_din(din[0]), .if_full_n(full_n[0]),
    .if_read(rd[0]), .if_dout(dout[0]), .if_empty_n(empty_n[0]));
  srl_fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .DEPTH(2)) u_d2 (
    .clk(clk), .ap_rst_n(rst_n), .if_write(wr[1]), .if_din(din[1]), .if_full_n(full_n[1]),
    .if_read(rd[1]), .if_dout(dout[1]), .if_empty_n(empty_n[1]));
  srl_fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .DEPTH(4)) u_d4 (
    .clk(clk), .ap_rst_n(rst_n), .if_write(wr[2]), .if_din(din[2]), .if_full_n(full_n[2]),
    .if_read(rd[2]), .if_dout(dout[2]), .if_empty_n(empty_n[2]));
  srl_fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .DEPTH(5)) u_d5 (
    .clk(clk), .ap_rst_n(rst_n), .if_write(wr[3]), .if_din(din[3]), .if_full_n(full_n[3]),
    .if_read(rd[3]), .if_dout(dout[3]), .if_empty_n(empty_n[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_full(input int k);
    return mcnt[k] < dep[k];
  endfunction

  function automatic bit exp_ne(input int k);
    return OREG ? hv[k] : (mcnt[k] != 0);
  endfunction

  function automatic logic [DW-1:0] exp_dout(input int k);
    return OREG ? head[k] : mbuf[k][mrd[k]];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      mcnt[k] = 0;
      mrd[k]  = 0;
      hv[k]   = 1'b0;
      head[k] = '0;
    end
  endtask

  task automatic idle();
    for (int k = 0; k < N; k++) begin
      wr[k] = 1'b0;
      rd[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("full_n[%0d]", k), full_n[k], exp_full(k));
      chk($sformatf("empty_n[%0d]", k), empty_n[k], exp_ne(k));
      if (exp_ne(k)) chk($sformatf("dout[%0d]", k), dout[k], exp_dout(k));
    end
  endtask

  // Called at a falling edge with inputs applied; advances model and DUT one clock.
  task automatic cycle();
    for (int k = 0; k < N; k++) begin
      bit wa, ra, pp;
      wa = wr[k] && exp_full(k);
      ra = rd[k] && exp_ne(k);
      pp = OREG ? ((mcnt[k] != 0) && (!hv[k] || ra)) : ra;
      if (OREG && ra) hv[k] = 1'b0;
      if (pp) begin
        if (OREG) begin
          head[k] = mbuf[k][mrd[k]];
          hv[k]   = 1'b1;
        end
        mrd[k]  = (mrd[k] + 1) % 8;
        mcnt[k] = mcnt[k] - 1;
      end
      if (wa) begin
        mbuf[k][(mrd[k] + mcnt[k]) % 8] = din[k];
        mcnt[k] = mcnt[k] + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_clear();
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_full_n[%0d]", k), full_n[k], 1);
      chk($sformatf("rst_empty_n[%0d]", k), empty_n[k], 0);
`ifdef SRL_FIFO_OUT_REG_EN
      chk($sformatf("rst_dout[%0d]", k), dout[k], 0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pw, pr;
    rst_n = 1'b0;
    idle();
    for (int k = 0; k < N; k++) din[k] = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Write-to-empty_n latency on DEPTH=2
    wr[1] = 1'b1; din[1] = 8'h01; cycle(); wr[1] = 1'b0;
`ifdef SRL_FIFO_OUT_REG_EN
    chk("lat_c1_empty_n", empty_n[1], 0);
    cycle();
    chk("lat_c2_empty_n", empty_n[1], 1);
    chk("lat_c2_dout", dout[1], 8'h01);
`else
    chk("lat_c1_empty_n", empty_n[1], 1);
    chk("lat_c1_dout", dout[1], 8'h01);
`endif
    rd[1] = 1'b1; cycle(); rd[1] = 1'b0; cycle();
    @(negedge clk);
    do_reset();

    // Fill DEPTH=2, ignored write when full, simultaneous write+read at full
    wr[1] = 1'b1; din[1] = 8'h0A; cycle();
    din[1] = 8'h0B; cycle();
`ifndef SRL_FIFO_OUT_REG_EN
    chk("full_after_2", full_n[1], 0);
`endif
    din[1] = 8'h0C; cycle();
`ifndef SRL_FIFO_OUT_REG_EN
    chk("full_head_A", dout[1], 8'h0A);
`endif
    rd[1] = 1'b1; cycle();
`ifndef SRL_FIFO_OUT_REG_EN
    chk("full_rw_full_n", full_n[1], 1);
    chk("full_rw_head_B", dout[1], 8'h0B);
`endif
    wr[1] = 1'b0;
    repeat (3) cycle();
    rd[1] = 1'b0;
`ifndef SRL_FIFO_OUT_REG_EN
    chk("drained_empty_n", empty_n[1], 0);
`endif
    @(negedge clk);
    do_reset();

    // Steady streaming on DEPTH=4 at two words of occupancy
    wr[2] = 1'b1; din[2] = 8'd0; cycle();
    din[2] = 8'd1; cycle();
    rd[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din[2] = DW'(i + 2);
      cycle();
    end
    idle();
`ifndef SRL_FIFO_OUT_REG_EN
    chk("stream_head", dout[2], 8'd10);
    chk("stream_empty_n", empty_n[2], 1);
`endif
    cycle();

    // Asynchronous reset with three words queued on DEPTH=5
    wr[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[3] = DW'(8'h30 + i);
      cycle();
    end
    wr[3] = 1'b0;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("arst_empty_n", empty_n[3], 0);
    chk("arst_full_n", full_n[3], 1);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
    wr[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[3] = DW'(8'h50 + i);
      cycle();
    end
    wr[3] = 1'b0; rd[3] = 1'b1;
    repeat (5) cycle();
    idle();

    // Randomised traffic, all depths in parallel, bias changing per phase
    for (int ph = 0; ph < 10; ph++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int c = 0; c < 1000; c++) begin
        for (int k = 0; k < N; k++) begin
          wr[k]  = ($urandom_range(0, 99) < pw);
          rd[k]  = ($urandom_range(0, 99) < pr);
          din[k] = DW'($urandom);
        end
        cycle();
      end
    end
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
